// File: rtl/mem_rmw_unit_if.sv
`default_nettype none
// ============================================================================
//  mem_rmw_unit_if
//  Request/response and memory-port bundle for the load/store sequencer.
//  Revision: 1.0
// ============================================================================
interface mem_rmw_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_data;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [1:0]            resp_fault;

    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic [31:0]           mem_read_data;
    logic                  mem_read_exception;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [31:0]           mem_write_data;
    logic                  mem_write_exception;

    // Unit side
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_address, req_data,
        input  resp_ready,
        input  mem_read_data, mem_read_exception, mem_write_exception,
        output req_ready, resp_valid, resp_data, resp_fault,
        output mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );

    // Core + memory side
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_address, req_data,
        output resp_ready,
        output mem_read_data, mem_read_exception, mem_write_exception,
        input  req_ready, resp_valid, resp_data, resp_fault,
        input  mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_rmw_unit.sv
`default_nettype none
// ============================================================================
//  mem_rmw_unit
//  Byte/half/word load-store sequencer over a word-only 32-bit memory;
//  sub-word stores are done as read-modify-write of the containing word.
//  Option: MEM_RMW_WORD_BYPASS_EN lets aligned word stores skip the read.
//  Revision: 1.0
// ============================================================================
module mem_rmw_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_rmw_unit_if.slave  bus
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $fatal(1, "mem_rmw_unit: DATA_WIDTH must be 32");
        end
    endgenerate

    localparam logic [1:0] SIZE_BYTE     = 2'd0;
    localparam logic [1:0] SIZE_HALF     = 2'd1;
    localparam logic [1:0] SIZE_WORD     = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL  = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ALIGN   = 2'd1;
    localparam logic [1:0] FAULT_ACCESS  = 2'd2;
    localparam logic [1:0] FAULT_SIZE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic [1:0]            resp_fault_q, resp_fault_d;
    logic [ADDR_WIDTH-1:0] mem_read_address_q, mem_read_address_d;
    logic [ADDR_WIDTH-1:0] mem_write_address_q, mem_write_address_d;
    logic [31:0]           mem_write_data_q, mem_write_data_d;

    logic                  op_store_q, op_store_d;
    logic [1:0]            op_size_q, op_size_d;
    logic                  op_unsigned_q, op_unsigned_d;
    logic [1:0]            op_lane_q, op_lane_d;
    logic [ADDR_WIDTH-1:0] op_wa_q, op_wa_d;
    logic [31:0]           op_data_q, op_data_d;

    logic [ADDR_WIDTH-1:0] req_wa;
    logic [1:0]            req_lane;
    logic                  req_misaligned;

    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        zero_ext
    );
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: result = zero_ext ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = zero_ext ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default:   result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] mask;
        logic [4:0]  sh;
        case (size)
            SIZE_BYTE: mask = 32'h0000_00FF;
            SIZE_HALF: mask = 32'h0000_FFFF;
            default:   mask = 32'hFFFF_FFFF;
        endcase
        sh = {lane, 3'b000};
        return (word & ~(mask << sh)) | ((data & mask) << sh);
    endfunction

    assign req_wa         = {bus.req_address[ADDR_WIDTH-1:2], 2'b00};
    assign req_lane       = bus.req_address[1:0];
    assign req_misaligned = ((bus.req_size == SIZE_HALF) && req_lane[0]) ||
                            ((bus.req_size == SIZE_WORD) && (req_lane != 2'd0));

    always_comb begin
        state_d             = state_q;
        req_ready_d         = req_ready_q;
        resp_valid_d        = resp_valid_q;
        resp_data_d         = resp_data_q;
        resp_fault_d        = resp_fault_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        op_store_d          = op_store_q;
        op_size_d           = op_size_q;
        op_unsigned_d       = op_unsigned_q;
        op_lane_d           = op_lane_q;
        op_wa_d             = op_wa_q;
        op_data_d           = op_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_store_d    = bus.req_store;
                    op_size_d     = bus.req_size;
                    op_unsigned_d = bus.req_unsigned;
                    op_lane_d     = req_lane;
                    op_wa_d       = req_wa;
                    op_data_d     = bus.req_data;
                    req_ready_d   = 1'b0;
                    if (bus.req_size == SIZE_ILLEGAL) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = 32'd0;
                        resp_fault_d = FAULT_SIZE;
                    end else if (req_misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = 32'd0;
                        resp_fault_d = FAULT_ALIGN;
`ifdef MEM_RMW_WORD_BYPASS_EN
                    end else if (bus.req_store && (bus.req_size == SIZE_WORD)) begin
                        state_d             = S_WRITE;
                        mem_write_address_d = req_wa;
                        mem_write_data_d    = bus.req_data;
`endif
                    end else begin
                        state_d            = S_READ;
                        mem_read_address_d = req_wa;
                    end
                end
            end

            S_READ: begin
                if (bus.mem_read_exception) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = 32'd0;
                    resp_fault_d = FAULT_ACCESS;
                end else if (op_store_q) begin
                    state_d             = S_WRITE;
                    mem_write_address_d = op_wa_q;
                    mem_write_data_d    = merge_store(bus.mem_read_data, op_data_q,
                                                      op_size_q, op_lane_q);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = extract_load(bus.mem_read_data, op_size_q,
                                                op_lane_q, op_unsigned_q);
                    resp_fault_d = FAULT_NONE;
                end
            end

            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'd0;
                resp_fault_d = bus.mem_write_exception ? FAULT_ACCESS : FAULT_NONE;
            end

            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= S_IDLE;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_data_q         <= 32'd0;
            resp_fault_q        <= FAULT_NONE;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= 32'd0;
            op_store_q          <= 1'b0;
            op_size_q           <= SIZE_BYTE;
            op_unsigned_q       <= 1'b0;
            op_lane_q           <= 2'd0;
            op_wa_q             <= '0;
            op_data_q           <= 32'd0;
        end else begin
            state_q             <= state_d;
            req_ready_q         <= req_ready_d;
            resp_valid_q        <= resp_valid_d;
            resp_data_q         <= resp_data_d;
            resp_fault_q        <= resp_fault_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            op_store_q          <= op_store_d;
            op_size_q           <= op_size_d;
            op_unsigned_q       <= op_unsigned_d;
            op_lane_q           <= op_lane_d;
            op_wa_q             <= op_wa_d;
            op_data_q           <= op_data_d;
        end
    end

    // The strobe must react to the same-cycle write exception and to an
    // asynchronous reset, so it is decoded from state rather than registered.
    assign bus.mem_write_enable  = (state_q == S_WRITE) && !bus.mem_write_exception;

    assign bus.req_ready         = req_ready_q;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_data         = resp_data_q;
    assign bus.resp_fault        = resp_fault_q;
    assign bus.mem_read_address  = mem_read_address_q;
    assign bus.mem_write_address = mem_write_address_q;
    assign bus.mem_write_data    = mem_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_rmw_unit.sv
`default_nettype none
// ============================================================================
//  tb_mem_rmw_unit
//  Directed self-checking bench for mem_rmw_unit with a small memory model.
//  Revision: 1.0
// ============================================================================
module tb_mem_rmw_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_rmw_unit_if #(.ADDR_WIDTH(32)) bus ();

    mem_rmw_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Word memory: reads valid below 0x2000, writes valid below 0x1000.
    logic [31:0] mem [0:2047];
    logic        mem_loaded = 1'b0;
    int          we_count   = 0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
            mem[64]   <= 32'h8899AABB;
            mem[65]   <= 32'h11223344;
            mem[1536] <= 32'h55555555;
            mem_loaded <= 1'b1;
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_write_address[12:2]] <= bus.mem_write_data;
            we_count <= we_count + 1;
        end
    end

    assign bus.mem_read_data       = mem[bus.mem_read_address[12:2]];
    assign bus.mem_read_exception  = (bus.mem_read_address  >= 32'h2000);
    assign bus.mem_write_exception = (bus.mem_write_address >= 32'h1000);

    logic [31:0] r_data;
    logic [1:0]  r_fault;
    int          r_lat;
    int          r_wr_seen;
    int          r_wr_lat;

    localparam int STORE_WORD_LAT =
`ifdef MEM_RMW_WORD_BYPASS_EN
        2;
`else
        3;
`endif

    // Issue one request from a negedge and wait (bounded) for resp_valid.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_data     = data;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        r_lat     = 1;
        r_wr_seen = 0;
        r_wr_lat  = 0;
        while (!bus.resp_valid && r_lat < 20) begin
            if (bus.mem_write_enable) begin
                r_wr_seen++;
                r_wr_lat = r_lat;
            end
            @(negedge clk);
            r_lat++;
        end
        r_data  = bus.resp_data;
        r_fault = bus.resp_fault;
    endtask

    task automatic complete();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [133:0] got;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        got = {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.resp_data,
               bus.mem_write_enable, bus.mem_read_address, bus.mem_write_address,
               bus.mem_write_data};
        tests_run++;
        if (got !== {1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want req_ready=1 and all else 0", got);
        end
    endtask

    typedef struct packed {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_load();
        ld_vec_t v [9];
        v[0] = '{2'd0, 1'b0, 32'h101, 32'hFFFFFFAA};
        v[1] = '{2'd1, 1'b1, 32'h102, 32'h00008899};
        v[2] = '{2'd0, 1'b1, 32'h100, 32'h000000BB};
        v[3] = '{2'd0, 1'b0, 32'h100, 32'hFFFFFFBB};
        v[4] = '{2'd0, 1'b1, 32'h103, 32'h00000088};
        v[5] = '{2'd1, 1'b0, 32'h102, 32'hFFFF8899};
        v[6] = '{2'd1, 1'b0, 32'h100, 32'hFFFFAABB};
        v[7] = '{2'd2, 1'b0, 32'h100, 32'h8899AABB};
        v[8] = '{2'd0, 1'b0, 32'h104, 32'h00000044};
        for (int i = 0; i < 9; i++) begin
            issue(1'b0, v[i].sz, v[i].uns, v[i].addr, 32'h0);
            tests_run++;
            if (r_data !== v[i].exp || r_fault !== 2'd0 || r_lat != 2) begin
                tests_failed++;
                $display("FAIL load[%0d]: got data=%h fault=%0d lat=%0d want data=%h fault=0 lat=2",
                         i, r_data, r_fault, r_lat, v[i].exp);
            end
            complete();
        end
    endtask

    task automatic test_store_rmw();
        int we0;
        we0 = we_count;
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'hFFFFFF11);
        tests_run++;
        if (r_lat != 3 || r_wr_seen != 1 || r_wr_lat != 2 || r_fault !== 2'd0 || r_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL sb_timing: got lat=%0d writes=%0d wr_at=%0d fault=%0d data=%h want 3 1 2 0 0",
                     r_lat, r_wr_seen, r_wr_lat, r_fault, r_data);
        end
        complete();
        tests_run++;
        if (mem[64] !== 32'h1199AABB || we_count != we0 + 1) begin
            tests_failed++;
            $display("FAIL sb_mem: got %h writes=%0d want 1199aabb writes=1", mem[64], we_count - we0);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        tests_run++;
        if (r_data !== 32'h1199AABB) begin
            tests_failed++;
            $display("FAIL sb_readback: got %h want 1199aabb", r_data);
        end
        complete();

        issue(1'b1, 2'd1, 1'b0, 32'h106, 32'hABCDCAFE);
        complete();
        issue(1'b1, 2'd0, 1'b0, 32'h105, 32'h0000005A);
        complete();
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        tests_run++;
        if (r_data !== 32'hCAFE5A44) begin
            tests_failed++;
            $display("FAIL sh_sb_merge: got %h want cafe5a44", r_data);
        end
        complete();

        issue(1'b1, 2'd2, 1'b0, 32'h108, 32'h01020304);
        tests_run++;
        if (r_lat != STORE_WORD_LAT || r_wr_seen != 1) begin
            tests_failed++;
            $display("FAIL sw_timing: got lat=%0d writes=%0d want %0d 1", r_lat, r_wr_seen, STORE_WORD_LAT);
        end
        complete();
        tests_run++;
        if (mem[66] !== 32'h01020304) begin
            tests_failed++;
            $display("FAIL sw_mem: got %h want 01020304", mem[66]);
        end
    endtask

    typedef struct packed {
        logic        st;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [1:0]  fault;
        logic [3:0]  lat;
    } flt_vec_t;

    task automatic test_faults();
        flt_vec_t v [8];
        int we0;
        v[0] = '{1'b0, 2'd1, 32'h101,  2'd1, 4'd1};
        v[1] = '{1'b1, 2'd1, 32'h103,  2'd1, 4'd1};
        v[2] = '{1'b0, 2'd2, 32'h102,  2'd1, 4'd1};
        v[3] = '{1'b1, 2'd2, 32'h101,  2'd1, 4'd1};
        v[4] = '{1'b0, 2'd3, 32'h100,  2'd3, 4'd1};
        v[5] = '{1'b1, 2'd3, 32'h103,  2'd3, 4'd1};
        v[6] = '{1'b0, 2'd2, 32'h3000, 2'd2, 4'd2};
        v[7] = '{1'b1, 2'd0, 32'h3001, 2'd2, 4'd2};
        for (int i = 0; i < 8; i++) begin
            we0 = we_count;
            issue(v[i].st, v[i].sz, 1'b0, v[i].addr, 32'hA5A5A5A5);
            complete();
            tests_run++;
            if (r_fault !== v[i].fault || r_data !== 32'd0 || r_lat != int'(v[i].lat) ||
                we_count != we0 || r_wr_seen != 0) begin
                tests_failed++;
                $display("FAIL fault[%0d]: got fault=%0d data=%h lat=%0d writes=%0d want fault=%0d data=0 lat=%0d writes=0",
                         i, r_fault, r_data, r_lat, we_count - we0, v[i].fault, v[i].lat);
            end
        end
    endtask

    task automatic test_write_fault_hold();
        int we0;
        we0 = we_count;
        issue(1'b1, 2'd2, 1'b0, 32'h1800, 32'hDEADBEEF);
        tests_run++;
        if (r_fault !== 2'd2 || r_wr_seen != 0 || r_lat != STORE_WORD_LAT) begin
            tests_failed++;
            $display("FAIL wr_fault: got fault=%0d strobes=%0d lat=%0d want 2 0 %0d",
                     r_fault, r_wr_seen, r_lat, STORE_WORD_LAT);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_fault, bus.resp_data} !==
                {1'b1, 1'b0, 2'd2, 32'd0}) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got valid=%b ready=%b fault=%0d data=%h want 1 0 2 0",
                         c, bus.resp_valid, bus.req_ready, bus.resp_fault, bus.resp_data);
            end
        end
        complete();
        tests_run++;
        if (mem[1536] !== 32'h55555555 || we_count != we0 || bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_fault_mem: got %h writes=%0d ready=%b want 55555555 0 1",
                     mem[1536], we_count - we0, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'd2, 1'b0, 32'h108, 32'h0);
        tests_run++;
        if (bus.req_ready !== 1'b0 || r_data !== 32'h01020304) begin
            tests_failed++;
            $display("FAIL b2b_first: got ready=%b data=%h want 0 01020304", bus.req_ready, r_data);
        end
        complete();
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b want 1", bus.req_ready);
        end
        issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        tests_run++;
        if (r_data !== 32'h000000AA || r_lat != 2) begin
            tests_failed++;
            $display("FAIL b2b_second: got data=%h lat=%0d want 000000aa 2", r_data, r_lat);
        end
        complete();
    endtask

    task automatic test_reset_mid_write();
        int we0;
        logic [132:0] got;
        we0 = we_count;
        bus.req_valid    = 1'b1;
        bus.req_store    = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'h104;
        bus.req_data     = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.mem_write_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_write_reached: got we=%b want 1", bus.mem_write_enable);
        end
        reset = 1'b1;
        #1;
        got = {bus.mem_write_enable, bus.req_ready, bus.resp_valid, bus.resp_fault, bus.resp_data,
               bus.mem_read_address, bus.mem_write_address, bus.mem_write_data};
        tests_run++;
        if (got !== {1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_mid_write: got %h want we=0 ready=1 others 0", got);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (we_count != we0 || mem[65] !== 32'hCAFE5A44) begin
            tests_failed++;
            $display("FAIL rst_no_write: got writes=%0d mem=%h want 0 cafe5a44", we_count - we0, mem[65]);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        tests_run++;
        if (r_data !== 32'hCAFE5A44 || r_lat != 2) begin
            tests_failed++;
            $display("FAIL rst_recover: got data=%h lat=%0d want cafe5a44 2", r_data, r_lat);
        end
        complete();
    endtask

    task automatic test_word_bypass();
        logic [31:0] exp_raddr;
`ifdef MEM_RMW_WORD_BYPASS_EN
        exp_raddr = 32'h100;
`else
        exp_raddr = 32'h200;
`endif
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        complete();
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
        tests_run++;
        if (r_lat != STORE_WORD_LAT || r_wr_seen != 1 || r_wr_lat != STORE_WORD_LAT - 1 ||
            bus.mem_read_address !== exp_raddr) begin
            tests_failed++;
            $display("FAIL sw_path: got lat=%0d writes=%0d wr_at=%0d raddr=%h want %0d 1 %0d %h",
                     r_lat, r_wr_seen, r_wr_lat, bus.mem_read_address,
                     STORE_WORD_LAT, STORE_WORD_LAT - 1, exp_raddr);
        end
        complete();
        tests_run++;
        if (mem[128] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL sw_bypass_mem: got %h want deadbeef", mem[128]);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'd0;
        bus.req_data     = 32'd0;
        bus.resp_ready   = 1'b0;

        test_reset();
        test_load();
        test_store_rmw();
        test_faults();
        test_write_fault_hold();
        test_back_to_back();
        test_reset_mid_write();
        test_word_bypass();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
